// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with boot sequencing, stall,
// branch/jump redirect, trap entry/return and a registered decode handoff.
module pc_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_ADDR = '0,
    parameter int              STEP       = 4,
    parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(32'h0000_0100),
    parameter int              BOOT_CYC   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redir_tgt,
    input  logic            trap,
    input  logic            trap_ret,
    output logic [XLEN-1:0] pc_out,
    output logic            fetch_valid,
    output logic [XLEN-1:0] id_pc,
    output logic            id_valid,
    output logic [XLEN-1:0] epc,
    output logic            misalign
);

    localparam int CNT_W = (BOOT_CYC > 1) ? $clog2(BOOT_CYC) : 1;

    typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] boot_cnt;
    logic            boot_done;

    logic [XLEN-1:0] pc_p0, pc_nxt;
    logic [XLEN-1:0] epc_q, epc_nxt;
    logic            mis_q, mis_nxt;
    logic [XLEN-1:0] id_pc_p1;
    logic            vld_p1;
    logic            run;
    logic            flush;

    // A target is usable only when its low log2(STEP) bits are clear.
    function automatic logic is_aligned(input logic [XLEN-1:0] tgt);
        return (tgt & XLEN'(STEP - 1)) == '0;
    endfunction

    assign boot_done = (boot_cnt == CNT_W'(BOOT_CYC - 1));
    assign run       = (state_q == RUN);
    assign flush     = run && (trap || trap_ret || redirect);

    // State register: BOOT after reset, RUN once the boot count expires.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= BOOT;
        else      state_q <= state_d;
    end

    // Next-state: BOOT leaves only after its last idle cycle; RUN is sticky.
    always_comb begin
        state_d = state_q;
        if (state_q == BOOT && boot_done) state_d = RUN;
    end

    // Output decode: fetches are valid only while running.
    always_comb begin
        fetch_valid = (state_q == RUN);
    end

    // Boot idle-cycle counter, advanced only while in BOOT.
    always_ff @(posedge clk) begin
        if (!rst)                               boot_cnt <= '0;
        else if (state_q == BOOT && !boot_done) boot_cnt <= boot_cnt + 1'b1;
    end

    // Next-PC selection by priority: trap, trap return, redirect, stall, step.
    always_comb begin
        pc_nxt  = pc_p0;
        epc_nxt = epc_q;
        mis_nxt = 1'b0;
        if (run) begin
            if (trap) begin
                epc_nxt = pc_p0;
                pc_nxt  = TRAP_VEC;
            end else if (trap_ret) begin
                pc_nxt = epc_q;
            end else if (redirect && is_aligned(redir_tgt)) begin
                pc_nxt = redir_tgt;
            end else if (redirect) begin
                mis_nxt = 1'b1;
                epc_nxt = redir_tgt;
                pc_nxt  = TRAP_VEC;
            end else if (!stall) begin
                pc_nxt = pc_p0 + XLEN'(STEP);
            end
        end
    end

    // Fetch stage (p0): PC, saved exception PC and misalign pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_p0 <= RESET_ADDR;
            epc_q <= '0;
            mis_q <= 1'b0;
        end else begin
            pc_p0 <= pc_nxt;
            epc_q <= epc_nxt;
            mis_q <= mis_nxt;
        end
    end

    // Decode stage (p1): flush kills the slot, stall holds it, else capture fetch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            id_pc_p1 <= '0;
            vld_p1   <= 1'b0;
        end else if (run) begin
            if (flush) begin
                vld_p1 <= 1'b0;
            end else if (!stall) begin
                id_pc_p1 <= pc_p0;
                vld_p1   <= fetch_valid;
            end
        end
    end

    assign pc_out   = pc_p0;
    assign id_pc    = id_pc_p1;
    assign id_valid = vld_p1;
    assign epc      = epc_q;
    assign misalign = mis_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scenarios plus randomized traffic against a
// behavioural model of the fetch PC unit.
module tb_pc_unit;

    localparam int XLEN     = 32;
    localparam int STEP     = 4;
    localparam int BOOT_CYC = 2;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            stall = 1'b0;
    logic            redirect = 1'b0;
    logic [XLEN-1:0] redir_tgt = '0;
    logic            trap = 1'b0;
    logic            trap_ret = 1'b0;
    logic [XLEN-1:0] pc_out;
    logic            fetch_valid;
    logic [XLEN-1:0] id_pc;
    logic            id_valid;
    logic [XLEN-1:0] epc;
    logic            misalign;

    int n_chk  = 0;
    int n_fail = 0;

    // behavioural model state
    int          m_boot;
    logic [31:0] m_pc, m_epc, m_idpc;
    logic        m_idv, m_mis;

    pc_unit #(
        .XLEN(XLEN), .RESET_ADDR(32'h0), .STEP(STEP),
        .TRAP_VEC(TRAP_VEC), .BOOT_CYC(BOOT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redir_tgt(redir_tgt), .trap(trap), .trap_ret(trap_ret),
        .pc_out(pc_out), .fetch_valid(fetch_valid), .id_pc(id_pc),
        .id_valid(id_valid), .epc(epc), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model, compare all outputs.
    task automatic step(input logic r, input logic st, input logic rd,
                        input logic [31:0] tgt, input logic tp, input logic tr);
        longint nxt;
        @(negedge clk);
        rst = r; stall = st; redirect = rd; redir_tgt = tgt; trap = tp; trap_ret = tr;
        @(posedge clk);
        if (!r) begin
            m_boot = BOOT_CYC; m_pc = 0; m_epc = 0; m_idpc = 0; m_idv = 0; m_mis = 0;
        end else if (m_boot > 0) begin
            m_boot--;
            m_mis = 0;
        end else begin
            if (tp || tr || rd) m_idv = 0;
            else if (!st) begin m_idpc = m_pc; m_idv = 1; end
            m_mis = 0;
            if (tp) begin m_epc = m_pc; m_pc = TRAP_VEC; end
            else if (tr) m_pc = m_epc;
            else if (rd && (tgt % STEP) == 0) m_pc = tgt;
            else if (rd) begin m_mis = 1; m_epc = tgt; m_pc = TRAP_VEC; end
            else if (!st) begin
                nxt = (longint'(m_pc) + STEP) % (64'd1 << 32);
                m_pc = nxt[31:0];
            end
        end
        #1;
        check("pc_out", pc_out, m_pc);
        check("fetch_valid", {31'b0, fetch_valid}, {31'b0, m_boot == 0});
        check("id_pc", id_pc, m_idpc);
        check("id_valid", {31'b0, id_valid}, {31'b0, m_idv});
        check("epc", epc, m_epc);
        check("misalign", {31'b0, misalign}, {31'b0, m_mis});
    endtask

    task automatic idle(input logic st);
        step(1'b1, st, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        m_boot = BOOT_CYC; m_pc = 0; m_epc = 0; m_idpc = 0; m_idv = 0; m_mis = 0;

        // T1: reset, boot idle, sequential fetch
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'h80, 1'b1, 1'b1);
        check("rst_pc", pc_out, 32'h0);
        check("rst_fv", {31'b0, fetch_valid}, 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 1'b0);   // ignored during boot
        check("boot_fv0", {31'b0, fetch_valid}, 32'h0);
        check("boot_pc", pc_out, 32'h0);
        idle(1'b0);
        check("run_fv1", {31'b0, fetch_valid}, 32'h1);
        idle(1'b0);
        idle(1'b0);
        check("t1_pc8", pc_out, 32'h8);
        check("t1_idpc4", id_pc, 32'h4);

        // T2: stall three cycles at pc=8
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            check("t2_pc_hold", pc_out, 32'h8);
            check("t2_id_hold", id_pc, 32'h4);
        end
        idle(1'b0);
        check("t2_resume", pc_out, 32'hC);

        // T3: redirect while stalled
        step(1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 1'b0);
        check("t3_pc", pc_out, 32'h40);
        check("t3_idv", {31'b0, id_valid}, 32'h0);
        idle(1'b0);

        // T4: trap then trap return
        check("t4_pc44", pc_out, 32'h44);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("t4_vec", pc_out, 32'h100);
        check("t4_epc", epc, 32'h44);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("t4_ret", pc_out, 32'h44);

        // T5: misaligned redirect, then back-to-back pulses
        step(1'b1, 1'b0, 1'b1, 32'h42, 1'b0, 1'b0);
        check("t5_mis", {31'b0, misalign}, 32'h1);
        check("t5_epc", epc, 32'h42);
        check("t5_pc", pc_out, 32'h100);
        step(1'b1, 1'b0, 1'b1, 32'h43, 1'b0, 1'b0);
        check("t5_mis_b2b", {31'b0, misalign}, 32'h1);
        idle(1'b0);
        check("t5_mis_clr", {31'b0, misalign}, 32'h0);

        // T6: wrap at top of address space, then reset mid-run
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        idle(1'b0);
        check("t6_wrap", pc_out, 32'h0);
        idle(1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("t6_rst_pc", pc_out, 32'h0);
        check("t6_rst_epc", epc, 32'h0);
        idle(1'b0);
        check("t6_boot_fv", {31'b0, fetch_valid}, 32'h0);
        idle(1'b0);
        check("t6_run_fv", {31'b0, fetch_valid}, 32'h1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic r, st, rd, tp, tr;
            logic [31:0] tgt;
            r   = ($urandom_range(0, 199) != 0);
            st  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 9) == 0);
            tp  = ($urandom_range(0, 19) == 0);
            tr  = ($urandom_range(0, 19) == 0);
            tgt = $urandom;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            step(r, st, rd, tgt, tp, tr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
